// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: one holding register in front of a shift register, so
// back-to-back words stream out with no idle bits between them.
module serial_word_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] din_i,
  input  logic             din_valid_i,
  output logic             din_ready_o,
  output logic             serout_o,
  output logic             ser_valid_o,
  output logic             word_done_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic [WIDTH-1:0] shift_q;
  logic [CntW-1:0]  cnt_q;

  logic             accept;
  logic [WIDTH-1:0] shift_next;

  // Ready depends only on registered state, never on din_valid_i.
  assign din_ready_o = ~hold_full_q;
  assign accept      = din_valid_i & ~hold_full_q;

  assign shift_next = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
    end else begin
      // Accept and hold-to-shift transfer are mutually exclusive: transfer needs
      // hold_full_q=1, accept needs hold_full_q=0.
      if (accept) begin
        hold_q      <= din_i;
        hold_full_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (hold_full_q) begin
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StShift;
          end
        end
        StShift: begin
          if (cnt_q == CntLast) begin
            cnt_q <= '0;
            if (hold_full_q) begin
              shift_q     <= hold_q;
              hold_full_q <= 1'b0;
            end else begin
              shift_q <= shift_next;
              state_q <= StIdle;
            end
          end else begin
            shift_q <= shift_next;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ser_valid_o = (state_q == StShift);
  assign serout_o    = ser_valid_o ? (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]) : IDLE_BIT;
  assign word_done_o = ser_valid_o && (cnt_q == CntLast);
  assign busy_o      = ser_valid_o | hold_full_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: MSB-first and LSB-first instances driven in parallel,
// checked every cycle against a word-timeline reference model.
module tb_serial_word_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;

  logic rdy_m, ser_m, val_m, done_m, busy_m;
  logic rdy_l, ser_l, val_l, done_l, busy_l;

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .din_i      (din),
    .din_valid_i(din_valid),
    .din_ready_o(rdy_m),
    .serout_o   (ser_m),
    .ser_valid_o(val_m),
    .word_done_o(done_m),
    .busy_o     (busy_m)
  );

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .din_i      (din),
    .din_valid_i(din_valid),
    .din_ready_o(rdy_l),
    .serout_o   (ser_l),
    .ser_valid_o(val_l),
    .word_done_o(done_l),
    .busy_o     (busy_l)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;             // posedges seen so far
  int last_s = -1000;    // start edge of the most recently accepted word

  // Each accepted word: accept edge, first-shift edge, data.
  int           e0_q[$];
  int           s_q[$];
  logic [W-1:0] w_q[$];

  logic ex_valid, ex_m, ex_l, ex_done, ex_busy, ex_ready;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, n, obs, exp);
    end
  endtask

  // Expected outputs in the cycle following edge n, from the word timeline.
  task automatic model_eval();
    logic         hold;
    logic [W-1:0] w;
    int           k;
    ex_valid = 1'b0;
    ex_m     = 1'b0;
    ex_l     = 1'b0;
    ex_done  = 1'b0;
    hold     = 1'b0;
    for (int i = 0; i < s_q.size(); i++) begin
      if (n >= s_q[i] && n < s_q[i] + W) begin
        w        = w_q[i];
        k        = n - s_q[i];
        ex_valid = 1'b1;
        ex_m     = w[W-1-k];
        ex_l     = w[k];
        ex_done  = (k == W - 1);
      end
      if (n >= e0_q[i] && n < s_q[i]) hold = 1'b1;
    end
    ex_busy  = ex_valid | hold;
    ex_ready = ~hold;
  endtask

  task automatic check_all();
    model_eval();
    chk("ready_m", rdy_m, ex_ready);
    chk("valid_m", val_m, ex_valid);
    chk("serout_m", ser_m, ex_m);
    chk("done_m", done_m, ex_done);
    chk("busy_m", busy_m, ex_busy);
    chk("ready_l", rdy_l, ex_ready);
    chk("valid_l", val_l, ex_valid);
    chk("serout_l", ser_l, ex_l);
    chk("done_l", done_l, ex_done);
    chk("busy_l", busy_l, ex_busy);
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, output bit acc);
    logic rdy;
    int   s;
    din_valid = v;
    din       = d;
    model_eval();
    rdy = ex_ready;
    @(posedge clk);
    acc = v && rdy && rst_n;
    n++;
    if (acc) begin
      s = (n + 1 > last_s + W) ? n + 1 : last_s + W;
      e0_q.push_back(n);
      s_q.push_back(s);
      w_q.push_back(d);
      last_s = s;
    end
    #1 check_all();
  endtask

  task automatic idle(input int cycles);
    bit acc;
    for (int i = 0; i < cycles; i++) step(1'b0, '0, acc);
  endtask

  task automatic send(input logic [W-1:0] w);
    bit acc = 1'b0;
    for (int t = 0; t < 4 * W && !acc; t++) step(1'b1, w, acc);
    chk("accept_timeout", acc, 1'b1);
  endtask

  task automatic clear_model();
    e0_q.delete();
    s_q.delete();
    w_q.delete();
    last_s = -1000;
  endtask

  initial begin
    bit           acc;
    bit           pend;
    logic         v;
    logic [W-1:0] rw;

    // Reset held with din_valid high: nothing accepted, outputs idle.
    rst_n = 1'b0;
    #1 check_all();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h55, acc);
    #3 rst_n = 1'b1;

    send(8'b1011_0010);
    idle(10);

    send(8'hA5);
    send(8'h3C);
    send(8'hFF);
    idle(3);
    idle(28);

    send(8'h01);
    idle(11);

    // Reset mid-word, between edges, once bit 3 of 8'hF0 is on the line.
    send(8'hF0);
    idle(4);
    #3 rst_n = 1'b0;
    clear_model();
    #1 check_all();
    idle(2);
    #3 rst_n = 1'b1;
    send(8'h81);
    idle(12);

    // Randomised traffic; din held stable while a word is pending.
    pend = 1'b0;
    v    = 1'b0;
    rw   = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        v  = ($urandom_range(0, 3) != 0);
        rw = W'($urandom);
      end
      step(v, rw, acc);
      pend = v && !acc;
    end
    idle(2 * W + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Upstream stage for the non-overlapping sequence detector. Its serout drives the detector's serin.
- Accepts parallel words over a valid/ready handshake and shifts each word out one bit per clock.
- One holding register plus one shift register, so back-to-back words stream with no idle bits between them.
- Gives the detector a deterministic, cycle-exact bit stream instead of free-running random stimulus.

Parameters:
- WIDTH, 8, word width in bits (2 to 32).
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
- IDLE_BIT, 0, level driven on serout while ser_valid=0.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- din  input  WIDTH  parallel word to serialise.
- din_valid  input  1  din is presented; must hold din stable until accepted.
- din_ready  output  1  holding register empty; word accepted at a posedge where din_valid=1 and din_ready=1.
- serout  output  1  serial bit to the detector's serin.
- ser_valid  output  1  serout carries a data bit this cycle.
- word_done  output  1  high for exactly the cycle carrying the last bit of a word.
- busy  output  1  high when the shift register or the holding register holds data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, hold_full=0, shift register=0, bit counter=0.
  - ser_valid=0, word_done=0, serout=IDLE_BIT, busy=0, din_ready=1.
  - Any in-flight word and any held word are discarded.
  - Release is sampled at posedge; the first accept is possible at the first posedge with rst=1.
- Handshake:
  - din_ready = ~hold_full, derived from registered state only, so there is no combinational path from din_valid to din_ready.
  - On accept at edge E0: hold_reg <= din, hold_full <= 1.
  - din_valid with din_ready=0 is ignored; the word is not lost and stays pending upstream.
- FSM states:
  - IDLE:
    - ser_valid=0, serout=IDLE_BIT.
    - At a posedge with hold_full=1: shift_reg <= hold_reg, hold_full <= 0, cnt <= 0, go to SHIFT.
  - SHIFT:
    - ser_valid=1; serout = shift_reg[WIDTH-1] if MSB_FIRST=1, else shift_reg[0].
    - Each posedge: shift by one toward the output end, zero fill, cnt <= cnt+1.
    - word_done = (cnt == WIDTH-1).
    - At the posedge ending the last bit, with hold_full=1: reload shift_reg from hold_reg, clear hold_full, cnt <= 0, stay in SHIFT. There is no gap bit.
    - At that posedge with hold_full=0: go to IDLE.
- Latency:
  - A word accepted at E0 into an empty block gets its first bit valid in the cycle after E1, where E1 = E0+1 clock.
  - Bit k is valid in the cycle after E1+k.
  - word_done is high in the cycle after E1+WIDTH-1.
- Simultaneous events:
  - The hold-to-shift transfer and an accept never coincide, because din_ready=0 while hold_full=1.
  - din_ready rises the cycle after the transfer, so the next accept happens while the current word is still shifting. Sustained throughput is one word per WIDTH clocks.
- Counter: $clog2(WIDTH) bits; never exceeds WIDTH-1; wraps to 0 on reload.
- Output timing:
  - All outputs come from registers or from register-only logic.
  - serout changes only just after posedge, so it is stable for the detector's next posedge sample.
- Mid-operation reset: serout returns to IDLE_BIT immediately; no partial word is resumed after release.

Test Plan:
- Reset check: hold rst=0 for 5 clocks with din_valid=1 -> din_ready=1, ser_valid=0, serout=0, word_done=0, busy=0 throughout; nothing accepted.
- Single word, WIDTH=8, MSB_FIRST=1: send din=8'b1011_0010 once -> after 1 clock, serout sequence 1,0,1,1,0,0,1,0 with ser_valid=1 for exactly 8 cycles; word_done only on the 8th; then IDLE with serout=0.
- Back-to-back: din_valid held high with words 8'hA5, 8'h3C, 8'hFF -> 24 contiguous valid bits 10100101 00111100 11111111; word_done at cycles 8, 16, 24; din_ready low exactly while hold_full=1.
- LSB-first, MSB_FIRST=0: send 8'h01 -> serout 1,0,0,0,0,0,0,0.
- End-to-end with detector: feed a word containing the target pattern twice (non-overlapping) -> detector det_out pulses exactly twice, aligned to the cycle after the last matching bit; stall upstream (din_valid=0) for 3 clocks -> serout=0, ser_valid=0 for those cycles.
- Reset mid-word: assert rst=0 asynchronously (between edges) after bit 3 of 8'hF0 -> serout, ser_valid, busy drop immediately; after release, next word 8'h81 shifts 1,0,0,0,0,0,0,1 with no residue from 8'hF0.
